// File: rtl/dmem_pkg.sv
// Shared widths, arbiter state encoding and reset constants for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Requester 1 counts as most recently served, so requester 0 wins the first tie.
    localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the requester not served last.
module rr_pick2 import dmem_pkg::*; (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid_c,
    output logic       o_winner_c
);

    always_comb begin
        o_valid_c  = |i_req;
        o_winner_c = 1'b0;
        if (i_req == 2'b11) begin
            o_winner_c = ~i_last;
        end else begin
            o_winner_c = i_req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and three-state access sequencer for the 16x4 data memory.
// Requester 0 is the datapath, requester 1 the loader/debug port.
module dmem_arbiter import dmem_pkg::*; #(
    parameter int unsigned ADDR_W = dmem_pkg::ADDR_W,
    parameter int unsigned DATA_W = dmem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_we,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r0_add,
    input  logic [ADDR_W-1:0] r1_add,
    input  logic [DATA_W-1:0] r0_wd,
    input  logic [DATA_W-1:0] r1_wd,
    output logic              r0_done,
    output logic              r1_done,
    output logic [DATA_W-1:0] r0_rd,
    output logic [DATA_W-1:0] r1_rd,
    output logic              busy,
    output logic [ADDR_W-1:0] M_add,
    output logic [DATA_W-1:0] M_wd,
    output logic              M_we,
    output logic              M_re,
    input  logic [DATA_W-1:0] M_rd
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_gnt;
    logic              r_last;
    logic              r_done0;
    logic              r_done1;
    logic              r_busy;
    logic [ADDR_W-1:0] r_m_add;
    logic [DATA_W-1:0] r_m_wd;
    logic              r_m_we;
    logic              r_m_re;
    logic [DATA_W-1:0] r_rd0;
    logic [DATA_W-1:0] r_rd1;

    logic              w_valid;
    logic              w_winner;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_add;
    logic [DATA_W-1:0] w_sel_wd;

    rr_pick2 u_pick (
        .i_req      ({r1_req, r0_req}),
        .i_last     (r_last),
        .o_valid_c  (w_valid),
        .o_winner_c (w_winner)
    );

    assign w_sel_we  = w_winner ? r1_we  : r0_we;
    assign w_sel_add = w_winner ? r1_add : r0_add;
    assign w_sel_wd  = w_winner ? r1_wd  : r0_wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_state_nxt = SERVE;
            SERVE:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory drive is latched from the winner in IDLE and held for exactly the SERVE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= 1'b0;
            r_last  <= LAST_RST;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_busy  <= 1'b0;
            r_m_add <= '0;
            r_m_wd  <= '0;
            r_m_we  <= 1'b0;
            r_m_re  <= 1'b0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_busy  <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_m_add <= w_sel_add;
                        r_m_wd  <= w_sel_wd;
                        r_m_we  <= w_sel_we;
                        r_m_re  <= ~w_sel_we;
                        r_gnt   <= w_winner;
                    end
                end
                SERVE: begin
                    r_m_we  <= 1'b0;
                    r_m_re  <= 1'b0;
                    r_last  <= r_gnt;
                    r_done0 <= ~r_gnt;
                    r_done1 <= r_gnt;
                    if (r_m_re) begin
                        if (r_gnt) begin
                            r_rd1 <= M_rd;
                        end else begin
                            r_rd0 <= M_rd;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign r0_done = r_done0;
    assign r1_done = r_done1;
    assign r0_rd   = r_rd0;
    assign r1_rd   = r_rd1;
    assign busy    = r_busy;
    assign M_add   = r_m_add;
    assign M_wd    = r_m_wd;
    assign M_we    = r_m_we;
    assign M_re    = r_m_re;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a 16x4 memory with identity initial contents, a transaction-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_req = 1'b0, r1_req = 1'b0;
    logic          r0_we = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r0_add = '0, r1_add = '0;
    logic [DW-1:0] r0_wd = '0, r1_wd = '0;
    logic          r0_done, r1_done, busy, M_we, M_re;
    logic [DW-1:0] r0_rd, r1_rd, M_wd, M_rd;
    logic [AW-1:0] M_add;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_add(r0_add), .r1_add(r1_add), .r0_wd(r0_wd), .r1_wd(r1_wd),
        .r0_done(r0_done), .r1_done(r1_done), .r0_rd(r0_rd), .r1_rd(r1_rd),
        .busy(busy), .M_add(M_add), .M_wd(M_wd), .M_we(M_we), .M_re(M_re), .M_rd(M_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment memory: no reset, asynchronous read, write on the clock edge.
    logic [DW-1:0] env_mem [16];
    assign M_rd = M_re ? env_mem[M_add] : '0;
    initial begin
        for (int i = 0; i < 16; i++) env_mem[i] = DW'(i);
        forever begin
            @(posedge clk);
            if (M_we) env_mem[M_add] <= M_wd;
        end
    end

    // Reference model: phase 0 idle, 1 memory access, 2 completion.
    int            m_phase = 0;
    logic          m_gnt = 1'b0, m_last = 1'b1, m_we = 1'b0;
    logic [AW-1:0] m_add = '0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_rd [2];
    logic [DW-1:0] ref_mem [16];
    bit            model_live = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = DW'(i);
        m_rd[0] = '0;
        m_rd[1] = '0;
        forever begin
            @(posedge clk);
            if (m_phase == 1 && m_we) ref_mem[m_add] = m_wd;
            if (rst) begin
                m_phase = 0; m_gnt = 1'b0; m_last = 1'b1; m_we = 1'b0;
                m_add = '0; m_wd = '0; m_rd[0] = '0; m_rd[1] = '0;
                model_live = 1'b1;
            end else begin
                case (m_phase)
                    0: if (r0_req || r1_req) begin
                        m_gnt = (r0_req && r1_req) ? !m_last : r1_req;
                        m_we  = m_gnt ? r1_we  : r0_we;
                        m_add = m_gnt ? r1_add : r0_add;
                        m_wd  = m_gnt ? r1_wd  : r0_wd;
                        m_phase = 1;
                    end
                    1: begin
                        if (!m_we) m_rd[m_gnt] = ref_mem[m_add];
                        m_last = m_gnt;
                        m_phase = 2;
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                chk("M_we",    int'(M_we),    int'(m_phase == 1 && m_we));
                chk("M_re",    int'(M_re),    int'(m_phase == 1 && !m_we));
                chk("M_add",   int'(M_add),   int'(m_add));
                chk("M_wd",    int'(M_wd),    int'(m_wd));
                chk("r0_done", int'(r0_done), int'(m_phase == 2 && !m_gnt));
                chk("r1_done", int'(r1_done), int'(m_phase == 2 && m_gnt));
                chk("busy",    int'(busy),    int'(m_phase != 0));
                chk("r0_rd",   int'(r0_rd),   int'(m_rd[0]));
                chk("r1_rd",   int'(r1_rd),   int'(m_rd[1]));
                chk("we_re_excl", int'(M_we && M_re), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic start(input int who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (who == 0) begin
            r0_req = 1'b1; r0_we = we; r0_add = a; r0_wd = d;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_add = a; r1_wd = d;
        end
    endtask

    task automatic stop(input int who);
        if (who == 0) r0_req = 1'b0;
        else          r1_req = 1'b0;
    endtask

    // Counts falling edges until the requester's done is seen; bounded.
    task automatic wait_done(input int who, output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if ((who == 0) ? r0_done : r1_done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk($sformatf("timeout_r%0d", who), 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_req = 1'b0;
        r1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int l0, l1, t0, t1, lat, run, maxrun;
    int order[$];
    int fa0[3] = '{1, 2, 4};
    int fa1[3] = '{6, 7, 8};

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_M_add", int'(M_add), 0);
        chk("rst_M_we", int'(M_we), 0);
        chk("rst_r0_rd", int'(r0_rd), 0);
        repeat (2) @(negedge clk);

        // single write then read
        start(0, 1'b1, 4'd5, 4'hA);
        @(negedge clk);
        chk("wr_M_we", int'(M_we), 1);
        chk("wr_M_add", int'(M_add), 5);
        chk("wr_M_wd", int'(M_wd), 10);
        @(negedge clk);
        chk("wr_done", int'(r0_done), 1);
        chk("wr_M_we_off", int'(M_we), 0);
        stop(0);
        @(negedge clk);
        chk("wr_done_pulse", int'(r0_done), 0);
        start(0, 1'b0, 4'd5, 4'h0);
        wait_done(0, lat);
        chk("rd_latency", lat, 2);
        chk("rd_data", int'(r0_rd), 10);
        stop(0);
        @(negedge clk);

        // contention from reset
        do_reset();
        fork
            begin start(0, 1'b0, 4'd3, 4'h0); wait_done(0, l0); t0 = cyc; stop(0); end
            begin start(1, 1'b0, 4'd12, 4'h0); wait_done(1, l1); t1 = cyc; stop(1); end
        join
        chk("cont_r0_lat", l0, 2);
        chk("cont_r1_lat", l1, 5);
        chk("cont_gap", t1 - t0, 3);
        chk("cont_r0_rd", int'(r0_rd), 3);
        chk("cont_r1_rd", int'(r1_rd), 12);
        @(negedge clk);

        // fairness under continuous reissue
        fork
            begin
                for (int j = 0; j < 3; j++) begin
                    start(0, 1'b0, AW'(fa0[j]), 4'h0);
                    wait_done(0, l0);
                    order.push_back(0);
                end
                stop(0);
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    start(1, 1'b0, AW'(fa1[j]), 4'h0);
                    wait_done(1, l1);
                    order.push_back(1);
                end
                stop(1);
            end
            begin
                @(negedge clk);
                run = 0;
                maxrun = 0;
                repeat (17) begin
                    @(negedge clk);
                    if (!busy) run++;
                    else run = 0;
                    if (run > maxrun) maxrun = run;
                end
            end
        join
        chk("fair_count", order.size(), 6);
        for (int i = 0; i < order.size(); i++) chk($sformatf("fair_order_%0d", i), order[i], i % 2);
        chk("fair_busy_gap", maxrun, 1);
        chk("fair_r0_rd", int'(r0_rd), 4);
        chk("fair_r1_rd", int'(r1_rd), 8);
        @(negedge clk);

        // write isolation: r1 writes, r0 reads the same address behind it
        start(1, 1'b1, 4'd9, 4'h7);
        @(negedge clk);
        start(0, 1'b0, 4'd9, 4'h0);
        wait_done(1, lat);
        chk("iso_r1_lat", lat, 1);
        stop(1);
        wait_done(0, lat);
        chk("iso_r0_lat", lat, 3);
        chk("iso_r0_rd", int'(r0_rd), 7);
        chk("iso_r1_rd", int'(r1_rd), 8);
        stop(0);
        @(negedge clk);

        // reset raised during SERVE of a write
        start(0, 1'b1, 4'd0, 4'h3);
        @(negedge clk);
        chk("rs_serve_we", int'(M_we), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_no_done", int'(r0_done), 0);
        chk("rs_r0_rd", int'(r0_rd), 0);
        chk("rs_r1_rd", int'(r1_rd), 0);
        chk("rs_busy", int'(busy), 0);
        r0_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        start(0, 1'b0, 4'd0, 4'h0);
        wait_done(0, lat);
        chk("rs_readback", int'(r0_rd), 3);
        stop(0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester round-robin arbiter and access sequencer for the 16×4 data memory. It owns the memory's `M_add`, `M_wd`, `M_we` and `M_re` inputs and returns `M_rd` to whichever requester holds the grant. Requester 0 is the processor datapath; requester 1 is the loader/debug port. Each access is a three-state transaction with a registered memory drive and a one-cycle `done` pulse.

## Interface
- `ADDR_W`, default 4: memory address width.
- `DATA_W`, default 4: memory data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `r0_req`, `r1_req`  in  1  access request; held high until `done`.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read; stable while `req` is high.
- `r0_add`, `r1_add`  in  ADDR_W  access address; stable while `req` is high.
- `r0_wd`, `r1_wd`  in  DATA_W  write data; stable while `req` is high.
- `r0_done`, `r1_done`  out  1  one-cycle completion pulse to the granted requester.
- `r0_rd`, `r1_rd`  out  DATA_W  read data; valid in the `done` cycle and held until the next completion for that requester.
- `busy`  out  1  high in SERVE and DONE.
- `M_add`  out  ADDR_W  memory address, registered.
- `M_wd`  out  DATA_W  memory write data, registered.
- `M_we`  out  1  memory write enable, registered.
- `M_re`  out  1  memory read enable, registered.
- `M_rd`  in  DATA_W  memory read data; combinational from `M_add` when `M_re` is high.

## Operation
FSM states: IDLE, SERVE, DONE.

**IDLE**
- If no `req` is high, remain in IDLE.
- Otherwise select one requester:
  - If only one `req` is high, select that requester.
  - If both are high, select the requester not equal to `last`. `last` is a 1-bit register holding the most recently served requester; its reset value is 1, so requester 0 wins the first tie.
- On the clock edge:
  - Register the winner's address into `M_add` and its data into `M_wd`.
  - Set `M_we` to the winner's `we`.
  - Set `M_re` to the inverse of the winner's `we`.
  - Store the winner index in `gnt`.
  - Go to SERVE.

**SERVE**
- The memory is driven for exactly this cycle.
- A write commits on the edge that ends SERVE.
- For a read, `M_rd` is captured on that same edge into the `rd` register of requester `gnt`.
- On that edge, clear `M_we` and `M_re` to 0, set `last` to `gnt`, and go to DONE.

**DONE**
- `r<gnt>_done` is 1 for this cycle only.
- Then go to IDLE.

**General rules**
- A write transaction leaves that requester's `rd` register unchanged.
- The other requester's `req` may stay high throughout; it is served from the next IDLE.
- A requester must drive `req` low in the cycle after its `done`, unless it intends a new transaction.
- Address and data are passed straight through; there is no arithmetic. All 16 addresses are legal.

## Timing
- Reset values: state = IDLE, `M_add` = 0, `M_wd` = 0, `M_we` = 0, `M_re` = 0, `gnt` = 0, `last` = 1, `r0_rd` = 0, `r1_rd` = 0, both `done` = 0, `busy` = 0.
- Latency: `req` sampled high in IDLE at cycle t → memory driven in cycle t+1 → `done` in cycle t+2. IDLE again at t+3.
- Throughput: at most one access per 3 cycles.
- Under constant contention, grants strictly alternate 0, 1, 0, 1, …
- `M_we` and `M_re` are never both 1. Both are 0 outside SERVE.
- Reset asserted while in SERVE:
  - A write in progress still commits on that edge, because the memory has no reset.
  - The controller goes to IDLE, no `done` is issued, and the `rd` registers are cleared.
- Reset asserted while in DONE: `done` is not issued after the edge.
- A `req` that drops before `done` is a protocol violation. The transaction still completes as latched.

## Structure
- Shared package `dmem_pkg` holds:
  - `ADDR_W` and `DATA_W` localparams (4 and 4);
  - the `arb_state_t` enum {IDLE, SERVE, DONE};
  - the reset constant for `last`.
- Sub-module `rr_pick2`: purely combinational. Takes `req[1:0]` and `last`; returns `valid` and `winner`.
- The FSM, the memory-drive registers and the `rd` registers live in `dmem_arbiter`.

## Test plan
- **Reset and idle:** assert `rst` 2 cycles with no requests → all outputs 0, `busy` = 0, no `M_we` ever.
- **Single write then read:**
  - `r0` writes 4'hA to address 5 → `M_we` = 1 with `M_add` = 5 for exactly 1 cycle, and `r0_done` 2 cycles after the request is sampled.
  - `r0` then reads address 5 → `r0_rd` = 4'hA in the `done` cycle.
- **Contention:** both requesters hold reads of addresses 3 and 12 from reset → `r0` is served first (`r0_rd` = 3, initial contents), then `r1` (`r1_rd` = 12). The `done` pulses are 3 cycles apart.
- **Fairness:** both requesters reissue continuously for 6 transactions → grant order 0, 1, 0, 1, 0, 1, and `busy` never drops for more than 1 cycle.
- **Write isolation:** `r1` writes 4'h7 to address 9 while `r0` reads address 9 queued behind it → `r0_rd` = 7. `r1_rd` keeps its previous value.
- **Reset mid-SERVE:** `r0` write of 4'h3 to address 0, with `rst` raised in the SERVE cycle → no `r0_done`. A later read of address 0 returns 3.
